counter_n: RTL and testbench

COUNTER_N -- requirements
Module: counter_n

---
 rtl/counter_n_pkg.sv | 13 +
 rtl/counter_n_prescale.sv | 29 ++
 rtl/counter_n.sv | 114 +++++++++++
 tb/tb_counter_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_n_pkg.sv
// Shared types for the counter_n block: count-mode encoding and its width.
package counter_n_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_UP_WRAP = 2'b00,
      MODE_DN_WRAP = 2'b01,
      MODE_UP_SAT  = 2'b10,
      MODE_DN_SAT  = 2'b11
   } mode_t;

endpackage

// File: rtl/counter_n_prescale.sv
// Enable-gated prescaler: issues one tick per presc+1 enabled cycles.
// Comparing with >= lets a lowered presc fire on the very next enabled cycle.
module counter_n_prescale #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] count;

   assign tick = en && (count >= presc);

   // Prescale count: cleared by load or on tick, advances only while enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr || tick) begin
         count <= '0;
      end else if (en) begin
         count <= count + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/counter_n.sv
// Up/down wrap/saturate counter with load, prescaled stepping, terminal-count
// pulse and compare match.
// Build option: COUNTER_N_PRESCALE_EN builds the prescaler; without it presc
// is ignored and the counter steps on every enabled cycle.
module counter_n
   import counter_n_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [MODE_W-1:0]  mode,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic [PRESC_W-1:0] presc,
   input  logic [WIDTH-1:0]   cmp_val,
   output logic [WIDTH-1:0]   counter,
   output logic               tc,
   output logic               match
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic             tick;
   mode_t            mode_sel;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] dn_val;
   logic [WIDTH-1:0] counter_next;
   logic             tc_next;
   logic             sat_hit;
   logic             sat_hit_next;

`ifdef COUNTER_N_PRESCALE_EN
   counter_n_prescale #(
      .PRESC_W (PRESC_W)
   ) u_prescale (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .presc (presc),
      .tick  (tick)
   );
`else
   logic unused_presc;
   assign unused_presc = ^presc;
   assign tick         = en;
`endif

   assign mode_sel = mode_t'(mode);
   assign up_val   = counter + ONE;
   assign dn_val   = counter - ONE;
   assign match    = (counter == cmp_val);

   // Next count and terminal-count decision; load overrides any step.
   // sat_hit marks a terminal value reached by saturating so tc fires once.
   always_comb begin
      counter_next = counter;
      tc_next      = 1'b0;
      sat_hit_next = sat_hit;
      if (load) begin
         counter_next = load_val;
         sat_hit_next = 1'b0;
      end else if (tick) begin
         case (mode_sel)
            MODE_UP_WRAP: begin
               counter_next = up_val;
               tc_next      = (counter == ALL_ONES);
               sat_hit_next = 1'b0;
            end
            MODE_DN_WRAP: begin
               counter_next = dn_val;
               tc_next      = (counter == ZERO);
               sat_hit_next = 1'b0;
            end
            MODE_UP_SAT: begin
               if (counter != ALL_ONES) begin
                  counter_next = up_val;
                  tc_next      = (up_val == ALL_ONES) && !sat_hit;
                  sat_hit_next = (up_val == ALL_ONES);
               end
            end
            MODE_DN_SAT: begin
               if (counter != ZERO) begin
                  counter_next = dn_val;
                  tc_next      = (dn_val == ZERO) && !sat_hit;
                  sat_hit_next = (dn_val == ZERO);
               end
            end
            default: begin
               counter_next = counter;
            end
         endcase
      end
   end

   // Count, tc and saturate flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         counter <= '0;
         tc      <= 1'b0;
         sat_hit <= 1'b0;
      end else begin
         counter <= counter_next;
         tc      <= tc_next;
         sat_hit <= sat_hit_next;
      end
   end

endmodule

// File: tb/tb_counter_n.sv
// Bench for counter_n (WIDTH=8): directed scenarios followed by randomized
// traffic, all compared against an arithmetic reference model.
module tb_counter_n;

`ifdef COUNTER_N_PRESCALE_EN
   localparam bit PRESC_ON = 1'b1;
`else
   localparam bit PRESC_ON = 1'b0;
`endif
   localparam int MAXV = 255;

   logic       clk;
   logic       reset;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] presc;
   logic [7:0] cmp_val;
   logic [7:0] counter;
   logic       tc;
   logic       match;

   int errors = 0;
   int checks = 0;

   int m_cnt = 0;
   int m_pre = 0;
   bit m_tc  = 1'b0;

   counter_n #(
      .WIDTH   (8),
      .PRESC_W (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .presc    (presc),
      .cmp_val  (cmp_val),
      .counter  (counter),
      .tc       (tc),
      .match    (match)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, expected finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour of one clock edge, from the counter's rules.
   task automatic model_edge();
      bit tk;
      tk = en && (!PRESC_ON || m_pre >= int'(presc));
      if (load) begin
         m_cnt = int'(load_val);
         m_pre = 0;
         m_tc  = 1'b0;
      end else begin
         m_tc = 1'b0;
         if (PRESC_ON && en) m_pre = tk ? 0 : m_pre + 1;
         if (tk) begin
            case (mode)
               2'b00: begin
                  m_tc  = (m_cnt == MAXV);
                  m_cnt = (m_cnt + 1) % (MAXV + 1);
               end
               2'b01: begin
                  m_tc  = (m_cnt == 0);
                  m_cnt = (m_cnt + MAXV) % (MAXV + 1);
               end
               2'b10: begin
                  if (m_cnt != MAXV) begin
                     m_cnt = m_cnt + 1;
                     m_tc  = (m_cnt == MAXV);
                  end
               end
               default: begin
                  if (m_cnt != 0) begin
                     m_cnt = m_cnt - 1;
                     m_tc  = (m_cnt == 0);
                  end
               end
            endcase
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("counter", 32'(counter), 32'(m_cnt));
      chk("tc", 32'(tc), 32'(m_tc));
      chk("match", 32'(match), 32'(m_cnt == int'(cmp_val)));
   endtask

   // Called 1 time unit after an edge; pulses reset well clear of both edges.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      m_cnt = 0;
      m_pre = 0;
      m_tc  = 1'b0;
      chk("rst_counter", 32'(counter), 32'h0);
      chk("rst_tc", 32'(tc), 32'h0);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset    = 1'b0;
      en       = 1'b0;
      mode     = 2'b00;
      load     = 1'b0;
      load_val = 8'h00;
      presc    = 8'h00;
      cmp_val  = 8'h80;

      #12;
      chk("reset_counter", 32'(counter), 32'h0);
      chk("reset_tc", 32'(tc), 32'h0);
      chk("reset_match", 32'(match), 32'h0);
      reset = 1'b1;

      // Up-wrap from 0, one step per cycle.
      en = 1'b1;
      for (int i = 0; i < 255; i++) step();
      chk("wrap_ff", 32'(counter), 32'hFF);
      step();
      chk("wrap_zero", 32'(counter), 32'h0);
      chk("wrap_tc", 32'(tc), 32'h1);
      step();
      chk("wrap_tc_once", 32'(tc), 32'h0);

      // presc=3: step every 4th enabled cycle, en gap delays the step.
      load = 1'b1; load_val = 8'h00; presc = 8'd3;
      step();
      load = 1'b0;
      for (int i = 0; i < 4; i++) step();
`ifdef COUNTER_N_PRESCALE_EN
      chk("presc_first", 32'(counter), 32'h1);
`endif
      step(); step();
      en = 1'b0;
      step(); step();
      en = 1'b1;
      step();
`ifdef COUNTER_N_PRESCALE_EN
      chk("presc_hold", 32'(counter), 32'h1);
`endif
      step();
`ifdef COUNTER_N_PRESCALE_EN
      chk("presc_delayed", 32'(counter), 32'h2);
`endif

      // Load with en low, then load colliding with a wrapping tick.
      en = 1'b0; presc = 8'd0; load = 1'b1; load_val = 8'h10;
      step();
      chk("load_val", 32'(counter), 32'h10);
      load_val = 8'hFF;
      step();
      en = 1'b1; load_val = 8'h33;
      step();
      chk("load_tick_cnt", 32'(counter), 32'h33);
      chk("load_tick_tc", 32'(tc), 32'h0);

      // Down-saturate from 2.
      mode = 2'b11; load_val = 8'h02;
      step();
      load = 1'b0;
      step();
      chk("dsat_01", 32'(counter), 32'h01);
      step();
      chk("dsat_00", 32'(counter), 32'h00);
      chk("dsat_tc", 32'(tc), 32'h1);
      step();
      chk("dsat_hold", 32'(counter), 32'h00);
      chk("dsat_tc_once", 32'(tc), 32'h0);
      step();

      // Compare match, then asynchronous reset at 0x25.
      mode = 2'b00; cmp_val = 8'h20; load = 1'b1; load_val = 8'h1E;
      step();
      load = 1'b0;
      step();
      chk("match_1f", 32'(match), 32'h0);
      step();
      chk("match_20", 32'(match), 32'h1);
      for (int i = 0; i < 5; i++) step();
      chk("cnt_25", 32'(counter), 32'h25);
      async_reset();
      step();
      chk("after_rst", 32'(counter), 32'h01);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         load = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 4))
            0: load_val = 8'hFE;
            1: load_val = 8'h01;
            2: load_val = 8'hFF;
            3: load_val = 8'h00;
            default: load_val = 8'($urandom);
         endcase
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 63) == 0) presc = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 15) == 0) cmp_val = 8'($urandom);
         step();
         if ($urandom_range(0, 249) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
